// File: rtl/spi_shift_engine.sv
// spi_shift_engine: byte-wide SPI mode-0 master shift engine.
// A start strobe launches one 8-bit transfer, sent MSB-first on mosi/sclk while
// miso is captured MSB-first. The SCLK half-period is chosen per transfer by a
// 2-bit speed code. busy covers the whole transfer, and data_out updates only
// on the completion edge.
module spi_shift_engine #(
    parameter int HALF_S0 = 16,
    parameter int HALF_S1 = 4,
    parameter int HALF_S2 = 2,
    parameter int HALF_S3 = 1
) (
    input  logic       clk7,
    input  logic       _reset,
    input  logic       start_write,
    input  logic       start_read,
    input  logic [7:0] data_in,
    input  logic [1:0] speed,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic       busy,
    output logic [7:0] data_out
);

    // The divider only ever holds H-1, so log2 of the largest H is wide enough.
    localparam int MAX_01 = (HALF_S0 > HALF_S1) ? HALF_S0 : HALF_S1;
    localparam int MAX_23 = (HALF_S2 > HALF_S3) ? HALF_S2 : HALF_S3;
    localparam int MAX_H  = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
    localparam int DW     = (MAX_H > 2) ? $clog2(MAX_H) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    tx_reg, tx_next;
    logic [7:0]    rx_reg, rx_next;
    logic [DW-1:0] div_reg, div_next;
    logic [2:0]    bit_reg, bit_next;
    logic [1:0]    speed_reg, speed_next;
    logic          sclk_reg, sclk_next;
    logic          mosi_reg, mosi_next;
    logic          busy_reg, busy_next;
    logic [7:0]    data_out_reg, data_out_next;

    // Divider reload value (half-period minus one) for a given speed code.
    function automatic logic [DW-1:0] reload(input logic [1:0] s);
        case (s)
            2'd0:    reload = DW'(HALF_S0 - 1);
            2'd1:    reload = DW'(HALF_S1 - 1);
            2'd2:    reload = DW'(HALF_S2 - 1);
            default: reload = DW'(HALF_S3 - 1);
        endcase
    endfunction

    // State and datapath registers; reset puts the SPI lines in their idle levels.
    always_ff @(posedge clk7 or negedge _reset) begin
        if (!_reset) begin
            state_reg    <= IDLE;
            tx_reg       <= 8'h00;
            rx_reg       <= 8'h00;
            div_reg      <= '0;
            bit_reg      <= 3'd0;
            speed_reg    <= 2'd0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b1;
            busy_reg     <= 1'b0;
            data_out_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            rx_reg       <= rx_next;
            div_reg      <= div_next;
            bit_reg      <= bit_next;
            speed_reg    <= speed_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            data_out_reg <= data_out_next;
        end
    end

    // Next-state logic: IDLE accepts a strobe, LOW/HIGH count out each SCLK half-period.
    always_comb begin
        state_next    = state_reg;
        tx_next       = tx_reg;
        rx_next       = rx_reg;
        div_next      = div_reg;
        bit_next      = bit_reg;
        speed_next    = speed_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        data_out_next = data_out_reg;

        case (state_reg)
            IDLE: begin
                // start_write takes priority when both strobes arrive together.
                if (start_write || start_read) begin
                    tx_next    = start_write ? data_in : 8'hFF;
                    mosi_next  = start_write ? data_in[7] : 1'b1;
                    speed_next = speed;
                    div_next   = reload(speed);
                    bit_next   = 3'd0;
                    busy_next  = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (div_reg == '0) begin
                    // Rising SCLK edge: the card's bit has been stable for H cycles.
                    sclk_next  = 1'b1;
                    rx_next    = {rx_reg[6:0], miso};
                    div_next   = reload(speed_reg);
                    state_next = HIGH;
                end else begin
                    div_next = div_reg - DW'(1);
                end
            end
            HIGH: begin
                if (div_reg == '0) begin
                    sclk_next = 1'b0;
                    if (bit_reg == 3'd7) begin
                        // Whole byte assembled; publish it in one step.
                        data_out_next = rx_reg;
                        busy_next     = 1'b0;
                        mosi_next     = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        tx_next    = {tx_reg[6:0], 1'b0};
                        mosi_next  = tx_reg[6];
                        bit_next   = bit_reg + 3'd1;
                        div_next   = reload(speed_reg);
                        state_next = LOW;
                    end
                end else begin
                    div_next = div_reg - DW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mosi     = mosi_reg;
    assign sclk     = sclk_reg;
    assign busy     = busy_reg;
    assign data_out = data_out_reg;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed testbench for spi_shift_engine (default speed parameters).
// A negedge monitor accumulates busy/sclk statistics and the mosi bit at each
// SCLK rise; the tests snapshot the counters and compare the deltas with
// hand-computed values.
module tb_spi_shift_engine;

    logic       clk7 = 1'b0;
    logic       _reset = 1'b0;
    logic       start_write = 1'b0;
    logic       start_read = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] speed = 2'd0;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic       busy;
    logic [7:0] data_out;

    logic       loop_mode = 1'b1;
    logic       card_load = 1'b0;
    logic [7:0] card_byte = 8'h00;
    logic [7:0] card_sr;

    int n_checks = 0;
    int n_fail   = 0;

    spi_shift_engine dut (
        .clk7        (clk7),
        ._reset      (_reset),
        .start_write (start_write),
        .start_read  (start_read),
        .data_in     (data_in),
        .speed       (speed),
        .miso        (miso),
        .mosi        (mosi),
        .sclk        (sclk),
        .busy        (busy),
        .data_out    (data_out)
    );

    always #5 clk7 = ~clk7;

    // Card model: presents its next bit after each SCLK falling edge.
    always @(negedge sclk or posedge card_load) begin
        if (card_load) card_sr <= card_byte;
        else           card_sr <= {card_sr[6:0], 1'b1};
    end

    assign miso = loop_mode ? mosi : card_sr[7];

    // Monitor counters (only this block writes them).
    int         cyc = 0;
    int         busy_cyc = 0;
    int         hi_cyc = 0;
    int         rises = 0;
    int         mosi_low = 0;
    int         dout_chg = 0;
    int         per_bad = 0;
    int         last_rise = -1;
    int         exp_period = 2;
    logic [7:0] mosi_log = 8'h00;
    logic       sclk_prev = 1'b0;
    logic [7:0] dout_prev = 8'h00;

    always @(negedge clk7) begin
        cyc = cyc + 1;
        if (busy) busy_cyc = busy_cyc + 1;
        if (sclk) hi_cyc = hi_cyc + 1;
        if (busy && !mosi) mosi_low = mosi_low + 1;
        if (busy && data_out !== dout_prev) dout_chg = dout_chg + 1;
        if (sclk && !sclk_prev) begin
            rises    = rises + 1;
            mosi_log = {mosi_log[6:0], mosi};
            if (last_rise >= 0 && (cyc - last_rise) != exp_period) per_bad = per_bad + 1;
            last_rise = cyc;
        end
        if (!busy) last_rise = -1;
        sclk_prev = sclk;
        dout_prev = data_out;
    end

    int b_busy, b_hi, b_rises, b_mlow, b_dchg, b_per;

    task automatic snap();
        b_busy  = busy_cyc;
        b_hi    = hi_cyc;
        b_rises = rises;
        b_mlow  = mosi_low;
        b_dchg  = dout_chg;
        b_per   = per_bad;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (observed !== expected) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk7);
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Called just after a negedge; returns at the first negedge with busy = 0.
    task automatic do_xfer(input logic wr, input logic rd, input logic [7:0] d, input logic [1:0] s);
        start_write = wr;
        start_read  = rd;
        data_in     = d;
        speed       = s;
        @(posedge clk7);
        @(negedge clk7);
        start_write = 1'b0;
        start_read  = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        wait_idle();
    endtask

    initial begin
        int n;

        // Reset state
        _reset = 1'b0;
        repeat (3) @(negedge clk7);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(data_out), 32'h00);
        _reset = 1'b1;
        @(negedge clk7);

        // Write 0xA5 at speed 3, loopback
        loop_mode = 1'b1;
        exp_period = 2;
        snap();
        do_xfer(1'b1, 1'b0, 8'hA5, 2'd3);
        check("a5_mosi_bits", 32'(mosi_log), 32'hA5);
        check("a5_busy_cyc", 32'(busy_cyc - b_busy), 32'd16);
        check("a5_rises", 32'(rises - b_rises), 32'd8);
        check("a5_sclk_hi", 32'(hi_cyc - b_hi), 32'd8);
        check("a5_period", 32'(per_bad - b_per), 32'd0);
        check("a5_dout", 32'(data_out), 32'hA5);
        check("a5_dout_stable", 32'(dout_chg - b_dchg), 32'd0);
        $display("xfer write 0xA5 speed3 -> data_out 0x%02h", data_out);

        // Read at speed 0 from card model returning 0x3C
        loop_mode = 1'b0;
        card_byte = 8'h3C;
        card_load = 1'b1;
        #1 card_load = 1'b0;
        exp_period = 32;
        snap();
        do_xfer(1'b0, 1'b1, 8'h00, 2'd0);
        check("rd_mosi_low", 32'(mosi_low - b_mlow), 32'd0);
        check("rd_mosi_bits", 32'(mosi_log), 32'hFF);
        check("rd_busy_cyc", 32'(busy_cyc - b_busy), 32'd256);
        check("rd_rises", 32'(rises - b_rises), 32'd8);
        check("rd_period", 32'(per_bad - b_per), 32'd0);
        check("rd_dout", 32'(data_out), 32'h3C);
        $display("xfer read speed0 -> data_out 0x%02h", data_out);

        // Write 0x12 at speed 3 with strobes and speed change mid-transfer
        loop_mode = 1'b1;
        exp_period = 2;
        snap();
        start_write = 1'b1;
        data_in = 8'h12;
        speed = 2'd3;
        @(posedge clk7);
        @(negedge clk7);
        start_write = 1'b0;
        repeat (3) @(negedge clk7);
        start_write = 1'b1;
        start_read  = 1'b1;
        data_in     = 8'hFF;
        speed       = 2'd0;
        @(negedge clk7);
        start_write = 1'b0;
        start_read  = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk7);
        check("ign_mosi_bits", 32'(mosi_log), 32'h12);
        check("ign_busy_cyc", 32'(busy_cyc - b_busy), 32'd16);
        check("ign_rises", 32'(rises - b_rises), 32'd8);
        check("ign_dout", 32'(data_out), 32'h12);
        $display("xfer write 0x12 speed3 with ignored strobes -> data_out 0x%02h", data_out);

        // Both strobes in the same cycle: write wins
        snap();
        do_xfer(1'b1, 1'b1, 8'h81, 2'd3);
        check("both_mosi_bits", 32'(mosi_log), 32'h81);
        check("both_dout", 32'(data_out), 32'h81);
        $display("xfer write+read 0x81 -> data_out 0x%02h", data_out);

        // Reset at bit 4 of a speed-1 transfer
        exp_period = 8;
        snap();
        start_write = 1'b1;
        data_in = 8'hC3;
        speed = 2'd1;
        @(posedge clk7);
        @(negedge clk7);
        start_write = 1'b0;
        n = 0;
        while ((rises - b_rises) < 4 && n < 1000) begin
            @(negedge clk7);
            n++;
        end
        check("mid_reached_bit4", 32'(rises - b_rises), 32'd4);
        _reset = 1'b0;
        #1;
        check("mid_rst_sclk", 32'(sclk), 32'd0);
        check("mid_rst_mosi", 32'(mosi), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dout", 32'(data_out), 32'h00);
        repeat (2) @(negedge clk7);
        _reset = 1'b1;
        @(negedge clk7);
        snap();
        do_xfer(1'b1, 1'b0, 8'h5A, 2'd1);
        check("post_rst_busy_cyc", 32'(busy_cyc - b_busy), 32'd64);
        check("post_rst_period", 32'(per_bad - b_per), 32'd0);
        check("post_rst_dout", 32'(data_out), 32'h5A);
        $display("xfer reset mid speed1, then write 0x5A -> data_out 0x%02h", data_out);

        // Back-to-back writes at speed 2
        exp_period = 4;
        snap();
        do_xfer(1'b1, 1'b0, 8'h01, 2'd2);
        check("b2b_first_dout", 32'(data_out), 32'h01);
        $display("xfer write 0x01 speed2 -> data_out 0x%02h", data_out);
        do_xfer(1'b1, 1'b0, 8'h80, 2'd2);
        check("b2b_second_dout", 32'(data_out), 32'h80);
        check("b2b_rises", 32'(rises - b_rises), 32'd16);
        check("b2b_sclk_hi", 32'(hi_cyc - b_hi), 32'd32);
        check("b2b_busy_cyc", 32'(busy_cyc - b_busy), 32'd64);
        check("b2b_period", 32'(per_bad - b_per), 32'd0);
        $display("xfer write 0x80 speed2 back-to-back -> data_out 0x%02h", data_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
